eh2_ram_rmw_ctrl: RTL



---
 rtl/eh2_ram_rmw_ctrl.sv | 71 +++++++
 1 files changed

// File: rtl/eh2_ram_rmw_ctrl.sv
// eh2_ram_rmw_ctrl: valid/ready front end for a non-byte-enabled single-port RAM macro, doing read-modify-write for partial writes
module eh2_ram_rmw_ctrl #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 64,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [AW-1:0]      req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  input  logic [WIDTH/8-1:0] req_wstrb,
  output logic               rsp_valid,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic               rsp_err,
  output logic               wr_err,
  output logic [AW-1:0]      ram_adr,
  output logic [WIDTH-1:0]   ram_d,
  output logic               ram_we,
  output logic               ram_me,
  input  logic [WIDTH-1:0]   ram_q
);
  typedef enum logic {IDLE, MERGE} state_t;
  state_t state;
  logic [AW-1:0] hold_addr;
  logic [WIDTH-1:0] hold_wdata, d_last, merged;
  logic [WIDTH/8-1:0] hold_wstrb;
  logic accept, in_rng, merge, rd, wf, wp;
  always_comb begin
    merge = state == MERGE;
    req_ready = ~rst & ~merge;
    accept = req_valid & req_ready;
    in_rng = 32'(req_addr) < DEPTH;
    rd = accept & ~req_write & in_rng;
    wf = accept & req_write & in_rng & (&req_wstrb);
    wp = accept & req_write & in_rng & ~(&req_wstrb) & (|req_wstrb);
    merged = '0;
    for (int b = 0; b < WIDTH / 8; b++)
      merged[8*b+:8] = hold_wstrb[b] ? hold_wdata[8*b+:8] : ram_q[8*b+:8];
    ram_me = ~rst & (rd | wf | wp | merge);
    ram_we = ~rst & (wf | merge);
    ram_adr = merge ? hold_addr : req_addr;
    ram_d = merge ? merged : wf ? req_wdata : d_last;
    rsp_rdata = rsp_err ? '0 : ram_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hold_addr <= '0;
      hold_wdata <= '0;
      hold_wstrb <= '0;
      d_last <= '0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      state <= wp ? MERGE : IDLE;
      if (wp) begin
        hold_addr <= req_addr;
        hold_wdata <= req_wdata;
        hold_wstrb <= req_wstrb;
      end
      if (ram_we) d_last <= ram_d;
      rsp_valid <= accept & ~req_write;
      rsp_err <= accept & ~req_write & ~in_rng;
      wr_err <= accept & req_write & ~in_rng;
    end
  end
endmodule
